mmc_spi_burst_transfer_layer: RTL

//  Single-clock SPI master byte engine for the MMC/SD controller, the successor of the fixed-rate byte layer.

---
 rtl/mmc_spi_burst_transfer_layer_if.sv | 24 ++
 rtl/mmc_spi_burst_transfer_layer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mmc_spi_burst_transfer_layer_if.sv
// Sequencer-side request/response bus of the MMC SPI burst byte engine.
interface mmc_spi_burst_transfer_layer_if #(
    parameter int unsigned P_CNT_W = 10
);
    logic               iMASTER_REQ;
    logic               oMASTER_LOCK;
    logic [7:0]         iMASTER_DATA;
    logic [P_CNT_W-1:0] iMASTER_BURST_LEN;
    logic               oMASTER_VALID;
    logic [7:0]         oMASTER_DATA;
    logic               oMASTER_LAST;
    logic [15:0]        oCRC16;
    logic               oCRC_OK;

    modport slave (
        input  iMASTER_REQ, iMASTER_DATA, iMASTER_BURST_LEN,
        output oMASTER_LOCK, oMASTER_VALID, oMASTER_DATA, oMASTER_LAST, oCRC16, oCRC_OK
    );

    modport master (
        output iMASTER_REQ, iMASTER_DATA, iMASTER_BURST_LEN,
        input  oMASTER_LOCK, oMASTER_VALID, oMASTER_DATA, oMASTER_LAST, oCRC16, oCRC_OK
    );
endinterface

// File: rtl/mmc_spi_burst_transfer_layer.sv
// SPI mode-0 master byte engine with run-time SCLK divider and multi-byte bursts.
// Optional CRC-16-CCITT over received bytes when MMC_SPI_BURST_CRC16_EN is defined.
module mmc_spi_burst_transfer_layer #(
    parameter int unsigned P_DIV_W = 8,
    parameter int unsigned P_CNT_W = 10
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iRESET_SYNC,
    input  logic [P_DIV_W-1:0]   iCLK_DIV,
    mmc_spi_burst_transfer_layer_if.slave m_if,
    output logic                 oMASTER_INFO_MISO,
    output logic                 oSPI_CLK,
    output logic                 oSPI_MOSI,
    input  logic                 iSPI_MISO
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;
    logic [P_CNT_W-1:0] rem_q, rem_d;
    logic [P_DIV_W-1:0] div_q, div_d;
    logic [P_DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic               lock_q, lock_d;
    logic               valid_q, valid_d;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;

`ifdef MMC_SPI_BURST_CRC16_EN
    logic [15:0]        crc_q, crc_d;
    logic               crc_ok_q, crc_ok_d;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
`ifdef MMC_SPI_BURST_CRC16_EN
        crc_d    = crc_q;
        crc_ok_d = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (m_if.iMASTER_REQ) begin
                    tx_d    = m_if.iMASTER_DATA;
                    rem_d   = m_if.iMASTER_BURST_LEN;
                    div_d   = iCLK_DIV;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_LOW;
`ifdef MMC_SPI_BURST_CRC16_EN
                    crc_d   = 16'h0000;
`endif
                end
            end
            ST_LOW: begin
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    rx_d    = {rx_q[6:0], iSPI_MISO};
                    state_d = ST_HIGH;
`ifdef MMC_SPI_BURST_CRC16_EN
                    crc_d   = crc16_step(crc_q, iSPI_MISO);
`endif
                end else begin
                    cnt_d = P_DIV_W'(cnt_q + P_DIV_W'(1));
                end
            end
            ST_HIGH: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_d   = 3'(bit_q + 3'd1);
                        state_d = ST_LOW;
                    end
                end else begin
                    cnt_d = P_DIV_W'(cnt_q + P_DIV_W'(1));
                end
            end
            ST_DONE: begin
                if (rem_q != '0) begin
                    rem_d   = P_CNT_W'(rem_q - P_CNT_W'(1));
                    tx_d    = 8'hFF;
                    bit_d   = '0;
                    state_d = ST_LOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs follow the state being entered so they line up with it
        lock_d = (state_d != ST_IDLE);
        sclk_d = (state_d == ST_HIGH);
        mosi_d = ((state_d == ST_LOW) || (state_d == ST_HIGH)) ? tx_d[~bit_d] : 1'b1;
        if (state_d == ST_DONE) begin
            valid_d = 1'b1;
            data_d  = rx_d;
            last_d  = (rem_q == '0);
`ifdef MMC_SPI_BURST_CRC16_EN
            crc_ok_d = (rem_q == '0) && (crc_d == 16'h0000);
`endif
        end

        if (iRESET_SYNC) begin
            state_d = ST_IDLE;
            lock_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = 8'h00;
            sclk_d  = 1'b0;
            mosi_d  = 1'b1;
`ifdef MMC_SPI_BURST_CRC16_EN
            crc_d    = 16'h0000;
            crc_ok_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= ST_IDLE;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            lock_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            lock_q  <= lock_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

`ifdef MMC_SPI_BURST_CRC16_EN
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            crc_q    <= 16'h0000;
            crc_ok_q <= 1'b0;
        end else begin
            crc_q    <= crc_d;
            crc_ok_q <= crc_ok_d;
        end
    end

    assign m_if.oCRC16  = crc_q;
    assign m_if.oCRC_OK = crc_ok_q;
`else
    assign m_if.oCRC16  = 16'h0000;
    assign m_if.oCRC_OK = 1'b0;
`endif

    assign m_if.oMASTER_LOCK  = lock_q;
    assign m_if.oMASTER_VALID = valid_q;
    assign m_if.oMASTER_DATA  = data_q;
    assign m_if.oMASTER_LAST  = last_q;
    assign oSPI_CLK           = sclk_q;
    assign oSPI_MOSI          = mosi_q;
    assign oMASTER_INFO_MISO  = iSPI_MISO;

endmodule
